// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared definitions for the round-robin FIFO write arbiter:
//   - state_t : arbiter FSM encoding (ST_IDLE=0, ST_GRANT=1)
//   - clog2() : constant function used to size index and counter fields
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Ceiling log2, never less than 1 so a field is always at least one bit.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/fifo_rr_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational rotating-priority picker. The search starts at last+1 and
//   wraps modulo NREQ, so the most recently served producer is tried last.
//   Ports:
//     req  in  NREQ          request vector
//     last in  clog2(NREQ)   index of the most recently served producer
//     any  out 1             at least one request is set
//     idx  out clog2(NREQ)   winning index (0 when any=0)
// ---------------------------------------------------------------------------
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]        req,
    input  logic [clog2(NREQ)-1:0] last,
    output logic                   any,
    output logic [clog2(NREQ)-1:0] idx
);

    localparam int IW = clog2(NREQ);

    logic found;
    int   cand;

    always_comb begin
        // NOTE: every variable gets a default before any conditional update so
        // no path leaves a value unassigned, which would infer a latch.
        any   = |req;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last) + k) % NREQ;
            if (!found && req[cand]) begin
                idx   = cand[IW-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_rr_wr_arbiter
//   Shares the write port of one FIFO_syn between NREQ producers. A producer
//   is picked round-robin and may write up to BURST consecutive words before
//   the grant is released; every grant is preceded by one IDLE cycle.
//   Ports:
//     clk          in   system clock, rising edge
//     reset        in   synchronous, active-high
//     req_valid    in   NREQ        producer i offers req_data slice i
//     req_data     in   NREQ*width  slice i = req_data[i*width +: width]
//     req_ready    out  NREQ        slice i accepted this cycle
//     fifo_wrEn    out  1           FIFO write strobe
//     fifo_wrData  out  width       FIFO write data (0 when not writing)
//     fifo_full    in   1           FIFO full backpressure
//     data_count   in   FIFO fill level, observability only
//     grant_id     out  producer currently granted
//     busy         out  1 while in GRANT
// ---------------------------------------------------------------------------
module fifo_rr_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int width = 8,
    parameter int depth = 8,
    parameter int BURST = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*width-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    fifo_wrEn,
    output logic [width-1:0]        fifo_wrData,
    input  logic                    fifo_full,
    input  logic [clog2(depth):0]   data_count,
    output logic [clog2(NREQ)-1:0]  grant_id,
    output logic                    busy
);

    localparam int IW = clog2(NREQ);
    localparam int BW = clog2(BURST + 1);

    state_t          state;
    logic [BW-1:0]   burst_cnt;
    logic [IW-1:0]   last;
    logic            pick_any;
    logic [IW-1:0]   pick_idx;
    logic            g_valid;
    logic            in_grant;
    logic            unused_data_count;

    // The fill level is carried through for observability only.
    assign unused_data_count = ^data_count;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req  (req_valid),
        .last (last),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign g_valid = req_valid[grant_id];

    // Reset masks the handshake immediately, even while the FSM register
    // still holds GRANT during the reset cycle.
    assign in_grant = (state == ST_GRANT) && !reset;
    assign busy     = in_grant;

    // Zero-latency write path: the accepted word goes straight to the FIFO on
    // the same edge as the producer handshake.
    always_comb begin
        req_ready   = '0;
        fifo_wrEn   = 1'b0;
        fifo_wrData = '0;
        if (in_grant && !fifo_full) begin
            req_ready[grant_id] = 1'b1;
            fifo_wrEn           = g_valid;
            if (g_valid) begin
                fifo_wrData = req_data[int'(grant_id)*width +: width];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (reset) begin
            state     <= ST_IDLE;
            grant_id  <= '0;
            burst_cnt <= '0;
            last      <= IW'(NREQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_id  <= pick_idx;
                        burst_cnt <= '0;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!g_valid) begin
                        // Producer went away: the rest of its burst is forfeited.
                        state <= ST_IDLE;
                        last  <= grant_id;
                    end else if (fifo_wrEn) begin
                        burst_cnt <= burst_cnt + BW'(1);
                        if (burst_cnt == BW'(BURST - 1)) begin
                            state <= ST_IDLE;
                            last  <= grant_id;
                        end
                    end
                    // fifo_full with a valid request: stall, grant held.
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_rr_wr_arbiter
//   Bench for fifo_rr_wr_arbiter with a behavioural 8x8 synchronous FIFO.
//   Words are tagged {producer[1:0], seq[5:0]}; expected words are queued per
//   producer when stimulus is loaded and popped by a monitor on FIFO reads.
// ---------------------------------------------------------------------------
module tb_fifo_rr_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int W     = 8;
    localparam int D     = 8;
    localparam int BURST = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              fifo_wrEn;
    logic [W-1:0]      fifo_wrData;
    logic              fifo_full;
    logic [3:0]        data_count;
    logic [1:0]        grant_id;
    logic              busy;

    always #10 clk = ~clk;

    fifo_rr_wr_arbiter #(
        .NREQ (NREQ),
        .width(W),
        .depth(D),
        .BURST(BURST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_wrEn  (fifo_wrEn),
        .fifo_wrData(fifo_wrData),
        .fifo_full  (fifo_full),
        .data_count (data_count),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    // ---------------- behavioural FIFO ----------------
    logic       fifo_rst;
    logic       rd_en;
    logic [7:0] mem [D];
    logic [2:0] wp, rp;
    logic [3:0] cnt;
    logic       rd_vld;
    logic [7:0] rd_data;
    logic       fifo_push, fifo_pop;

    assign fifo_full  = (cnt == 4'd8);
    assign data_count = cnt;
    assign fifo_push  = fifo_wrEn && !fifo_full;
    assign fifo_pop   = rd_en && (cnt != 4'd0);

    always @(posedge clk) begin
        if (fifo_rst) begin
            wp     <= '0;
            rp     <= '0;
            cnt    <= '0;
            rd_vld <= 1'b0;
            rd_data <= '0;
        end else begin
            if (fifo_push) begin
                mem[wp] <= fifo_wrData;
                wp      <= wp + 3'd1;
            end
            if (fifo_pop) begin
                rd_data <= mem[rp];
                rp      <= rp + 3'd1;
            end
            rd_vld <= fifo_pop;
            cnt    <= cnt + {3'b000, fifo_push} - {3'b000, fifo_pop};
        end
    end

    // ---------------- bench state ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc;
    int         tot_hs, tot_wr, tot_rd, max_cnt;
    logic       rst_lvl, rd_lvl, chk_cnt;
    logic [5:0] next_seq [NREQ];
    logic [7:0] src_q [NREQ][$];
    logic [7:0] exp_q [NREQ][$];

    logic       w_log [64];
    logic       b_log [64];
    logic       f_log [64];
    logic [1:0] g_log [64];
    logic [3:0] r_log [64];
    logic [7:0] d_log [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load(input int id, input int n);
        logic [7:0] word;
        logic [1:0] tag;
        for (int k = 0; k < n; k++) begin
            tag  = id[1:0];
            word = {tag, next_seq[id]};
            src_q[id].push_back(word);
            exp_q[id].push_back(word);
            next_seq[id] = next_seq[id] + 6'd1;
        end
    endtask

    // One clock cycle: drive on the falling edge, sample 1 unit later. The
    // sampled handshake/write is what the next rising edge will commit.
    task automatic tick();
        logic [NREQ-1:0] hs;
        @(negedge clk);
        reset = rst_lvl;
        rd_en = rd_lvl;
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[i*W +: W] = src_q[i][0];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*W +: W] = '0;
            end
        end
        #1;
        hs = req_valid & req_ready;
        if (cyc < 64) begin
            w_log[cyc] = fifo_wrEn;
            b_log[cyc] = busy;
            f_log[cyc] = fifo_full;
            g_log[cyc] = grant_id;
            r_log[cyc] = req_ready;
            d_log[cyc] = fifo_wrData;
        end
        if (fifo_full) check("no_write_when_full", 32'(fifo_wrEn), 32'd0);
        if (chk_cnt) check("data_count_vs_wr_rd", 32'(data_count), 32'(tot_wr - tot_rd));
        if (int'(data_count) > max_cnt) max_cnt = int'(data_count);
        tot_hs += $countones(hs);
        tot_wr += int'(fifo_wrEn);
        if (rd_en && data_count != 4'd0) tot_rd++;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) void'(src_q[i].pop_front());
        end
        cyc++;
    endtask

    function automatic logic all_idle();
        logic r;
        r = (data_count == 4'd0);
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() != 0) r = 1'b0;
        end
        return r;
    endfunction

    task automatic drain(input string name, input int bound);
        int k;
        rd_lvl = 1'b1;
        k = 0;
        while (k < bound && !all_idle()) begin
            tick();
            k++;
        end
        check(name, 32'(all_idle()), 32'd1);
        tick();
        tick();
    endtask

    function automatic logic [31:0] pack_w(input int n);
        logic [31:0] p;
        p = '0;
        for (int k = 0; k < n; k++) p = {p[30:0], w_log[k]};
        return p;
    endfunction

    function automatic logic [31:0] pack_b(input int n);
        logic [31:0] p;
        p = '0;
        for (int k = 0; k < n; k++) p = {p[30:0], b_log[k]};
        return p;
    endfunction

    function automatic int wsum(input int a, input int b);
        int s;
        s = 0;
        for (int k = a; k <= b; k++) s += int'(w_log[k]);
        return s;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : monitor
        int         key;
        logic [7:0] e;
        if (rd_vld) begin
            key = int'(rd_data[7:6]);
            check("sb_word_expected", 32'(exp_q[key].size() > 0), 32'd1);
            if (exp_q[key].size() > 0) begin
                e = exp_q[key].pop_front();
                check("sb_read_order", 32'(rd_data), 32'(e));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        rst_lvl   = 1'b1;
        rd_lvl    = 1'b0;
        rd_en     = 1'b0;
        fifo_rst  = 1'b1;
        req_valid = '0;
        req_data  = '0;
        chk_cnt   = 1'b0;
        tot_hs = 0; tot_wr = 0; tot_rd = 0; max_cnt = 0; cyc = 0;
        for (int i = 0; i < NREQ; i++) next_seq[i] = 6'd1;

        // Reset state
        tick();
        tick();
        check("rst_grant_id", 32'(g_log[1]), 32'd0);
        check("rst_busy",     32'(b_log[1]), 32'd0);
        check("rst_wren",     32'(w_log[1]), 32'd0);
        check("rst_ready",    32'(r_log[1]), 32'd0);
        fifo_rst = 1'b0;
        rst_lvl  = 1'b0;

        // 1: single producer, 6 words, burst split 4+2 with one bubble
        cyc = 0; max_cnt = 0;
        load(1, 6);
        repeat (10) tick();
        check("t1_wr_pattern",   pack_w(10), 32'b0111101100);
        check("t1_busy_pattern", pack_b(10), 32'b0111101110);
        check("t1_grant_first",  32'(g_log[1]), 32'd1);
        check("t1_grant_second", 32'(g_log[6]), 32'd1);
        check("t1_peak_count",   32'(max_cnt), 32'd6);
        drain("t1_drain", 40);

        // 2: all producers valid, FIFO drained every cycle
        rst_lvl = 1'b1; tick(); rst_lvl = 1'b0;
        cyc = 0;
        for (int i = 0; i < NREQ; i++) load(i, 8);
        rd_lvl = 1'b1;
        repeat (25) tick();
        begin
            int slot [5] = '{1, 6, 11, 16, 21};
            int gexp [5] = '{0, 1, 2, 3, 0};
            for (int k = 0; k < 5; k++)
                check("t2_grant_order", 32'(g_log[slot[k]]), 32'(gexp[k]));
        end
        check("t2_write_count",   32'(wsum(0, 24)), 32'd20);
        check("t2_busy_pattern",  pack_b(25), 32'({5{5'b01111}}));
        drain("t2_drain", 100);

        // 3: no reads, 10 words from producer 2, full backpressure
        cyc = 0; max_cnt = 0;
        rd_lvl = 1'b0;
        load(2, 10);
        repeat (15) tick();
        rd_lvl = 1'b1; tick();
        rd_lvl = 1'b0; tick(); tick();
        check("t3_writes_to_full", 32'(wsum(0, 14)), 32'd8);
        check("t3_full",           32'(f_log[11]), 32'd1);
        check("t3_ready_stall",    32'(r_log[12]), 32'd0);
        check("t3_wren_stall",     32'(w_log[13]), 32'd0);
        check("t3_grant_held",     32'(b_log[14] && g_log[14] == 2'd2), 32'd1);
        check("t3_peak_count",     32'(max_cnt), 32'd8);
        check("t3_read_cycle_wr",  32'(w_log[15]), 32'd0);
        check("t3_resume_wr",      32'(w_log[16]), 32'd1);
        check("t3_refull_wr",      32'(w_log[17]), 32'd0);
        drain("t3_drain", 60);

        // 4: producer 0 drops valid after 2 writes, producer 3 waiting
        rst_lvl = 1'b1; tick(); rst_lvl = 1'b0;
        cyc = 0;
        load(0, 2);
        load(3, 4);
        rd_lvl = 1'b1;
        repeat (10) tick();
        check("t4_grant0",       32'(g_log[1]), 32'd0);
        check("t4_p0_writes",    32'(wsum(0, 3)), 32'd2);
        check("t4_drop_no_wr",   32'(w_log[3]), 32'd0);
        check("t4_drop_busy",    32'(b_log[3]), 32'd1);
        check("t4_idle_bubble",  32'(b_log[4]), 32'd0);
        check("t4_grant3",       32'(g_log[5]), 32'd3);
        check("t4_full_burst3",  32'(wsum(5, 8)), 32'd4);
        check("t4_release",      32'(b_log[9]), 32'd0);
        drain("t4_drain", 40);

        // 5: reset mid-burst of producer 2
        cyc = 0;
        load(2, 6);
        load(3, 2);
        rd_lvl = 1'b1;
        repeat (3) tick();
        rst_lvl = 1'b1;
        load(0, 2);
        tick();
        rst_lvl = 1'b0;
        repeat (9) tick();
        check("t5_grant2",       32'(g_log[1]), 32'd2);
        check("t5_rst_wren",     32'(w_log[3]), 32'd0);
        check("t5_rst_busy",     32'(b_log[3]), 32'd0);
        check("t5_rst_ready",    32'(r_log[3]), 32'd0);
        check("t5_rst_wrdata",   32'(d_log[3]), 32'd0);
        check("t5_idle_after",   32'(b_log[4]), 32'd0);
        check("t5_p0_wins",      32'(g_log[5]), 32'd0);
        check("t5_p0_write",     32'(w_log[5]), 32'd1);
        drain("t5_drain", 60);

        // 6: random traffic
        chk_cnt = 1'b1;
        repeat (500) begin
            for (int i = 0; i < NREQ; i++) begin
                if (src_q[i].size() < 3 && $urandom_range(0, 3) == 0) load(i, 1);
            end
            rd_lvl = ($urandom_range(0, 1) == 1);
            tick();
        end
        drain("t6_drain", 300);

        for (int i = 0; i < NREQ; i++)
            check("sb_all_words_read", 32'(exp_q[i].size()), 32'd0);
        check("hs_equals_writes", 32'(tot_hs), 32'(tot_wr));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
